paged_ram_mapper: RTL and testbench
===================================

# paged_ram_mapper

Parametrised, clocked successor to the Aquarius oMega paged-RAM controller. It splits the 64KB Z80 space into 2^WIN_BITS windows, each backed by a page register of PAGE_BITS bits, and supports per-window enables, page readback and cartridge-aware disabling of the top window. Bus strobes are synchronised into one system clock, so there are no asynchronous edge-triggered registers. The block sits between the Aquarius expansion bus and the RAM chip-enable and upper-address pins on the expander CPLD.

## Interface
- WIN_BITS, 2, number of address-high bits that select a window; 2^WIN_BITS windows.
- PAGE_BITS, 6, page register width; legal range 1..7.
- SEL_PORT, 8'hE6, IO address of the window-select/control register.
- PAGE_PORT, 8'hE7, IO address of the page register for the selected window.
- MAP_MASK, 4'b1110, bit w = 1 means window w is pageable; window w never asserts its CE when its bit is 0.
- aq_clk  in  1  system clock, at least 4x Z80 clock. One clock domain.
- aq_reset  in  1  synchronous, active-high reset.
- aq_addr_hi  in  WIN_BITS  Z80 A15 downward; selects the window.
- aq_addr_lo  in  8  Z80 A7..A0; IO port decode.
- aq_data_in  in  8  Z80 data bus, input side.
- aq_data_out  out  8  readback data.
- aq_data_oe  out  1  high = drive aq_data_out onto the bus.
- aq_mreq_n, aq_iorq_n, aq_wr_n, aq_rd_n  in  1 each  Z80 strobes, active low, asynchronous.
- aq_cart_n  in  1  low = cartridge inserted; asynchronous.
- ram_ce_n  out  2^WIN_BITS  per-window RAM chip enable, active low.
- ram_page  out  PAGE_BITS  RAM upper address for the window being accessed.

## Operation
- Synchronisers: 2-FF synchronisers on iorq_n, wr_n, rd_n and cart_n. iowr = !iorq_s & !wr_s. iord = !iorq_s & !rd_s.
- Write strobe: a one-cycle pulse on the rising edge of iowr. In the pulse cycle, sample aq_addr_lo and aq_data_in directly; they are stable by Z80 IO timing.
- SEL_PORT write:
  - sel <= data[WIN_BITS-1:0].
  - If data[7] = 1, en[sel_new] <= data[6]. If data[7] = 0, enables are untouched.
  - Selecting a window with MAP_MASK = 0 is allowed. Its page register exists, but its CE stays high.
- PAGE_PORT write: page[sel] <= data[PAGE_BITS-1:0]. Upper data bits are ignored.
- SEL_PORT read returns {en[sel], 0 padding, sel}, with en[sel] in bit 7 and sel in the low WIN_BITS bits.
- PAGE_PORT read returns page[sel], zero-extended to 8 bits.
- Read enable: aq_data_oe = registered (iord & port match). Drop it the cycle after iord falls.
- Other ports: never drive the bus and never change state.
- Chip enables (combinational from the raw inputs): ram_ce_n[w] = !(!aq_mreq_n & aq_addr_hi == w & MAP_MASK[w] & en[w]).
- Page output (combinational): ram_page = page[aq_addr_hi]. Output 0 when MAP_MASK[aq_addr_hi] = 0.
- Cartridge:
  - While cart_s = 0, en[top] is forced to 0 and held at 0.
  - Writes that try to set en[top] while cart_s = 0 are ignored.
  - When cart_s returns to 1, en[top] stays 0 until it is rewritten.
- Reset:
  - page[*] = 0, sel = 0.
  - en[w] = MAP_MASK[w], except en[top] = 0.
  - aq_data_oe = 0, aq_data_out = 0.
  - ram_ce_n is all 1 while the enables are 0.

## Timing
- Write latency: iowr asserted at pins -> register updated at the end of clock 3 (2 sync + 1 pulse). The new value is visible on ram_page/ram_ce_n at clock 4.
- Readback: aq_data_oe rises 3 clocks after iord at pins and falls 3 clocks after it deasserts. At ≥4x Z80 clock, data is valid before the T3 sample point.
- One update per IO cycle. A held iowr produces one pulse only.
- Back-to-back SEL then PAGE writes: the PAGE write uses the sel value written by the preceding cycle.
- A cart_n fall and a same-cycle SEL write enabling top: the cartridge wins, and en[top] = 0.
- Reset asserted mid IO cycle: state clears. After release, no pulse is generated until iowr deasserts and reasserts. The edge detector resets with iowr_prev = 1.

## Test plan
- Reset, then MREQ read at 16'h4000 -> ram_ce_n = 4'b1101, ram_page = 0. Access at 16'hC000 -> ram_ce_n = 4'b1111.
- OUT E6,02; OUT E7,2A; access 16'h8000 -> ram_page = 6'h2A, ram_ce_n[2] = 0. Window 1 page remains 0.
- OUT E6,C3 with cart_n = 1; OUT E7,3F; access 16'hC000 -> ram_ce_n[3] = 0, ram_page = 3F. Drive cart_n = 0 -> within 3 clocks ram_ce_n[3] = 1. OUT E6,C3 again -> en[3] stays 0.
- OUT E6,01; OUT E7,15; IN E7 -> aq_data_oe pulses high, data = 8'h15. IN E6 -> 8'h81.
- OUT E7,FF with PAGE_BITS = 6 -> page = 6'h3F. OUT to port E5 -> no state change and aq_data_oe stays 0.
- Assert aq_reset during a held IOWR to E7 -> pages are 0 after reset, and no write occurs until the next fresh IOWR.

Source files
------------

// File: rtl/paged_ram_mapper.sv
// Paged-RAM mapper for the Aquarius expansion bus: 2^WIN_BITS windows, each with a
// page register, per-window enables, IO readback and cartridge-aware top window.
module paged_ram_mapper #(
  parameter int unsigned              WIN_BITS  = 2,
  parameter int unsigned              PAGE_BITS = 6,
  parameter logic [7:0]               SEL_PORT  = 8'hE6,
  parameter logic [7:0]               PAGE_PORT = 8'hE7,
  parameter logic [(2**WIN_BITS)-1:0] MAP_MASK  = 4'b1110
) (
  input  logic                         aq_clk,
  input  logic                         aq_reset,
  input  logic [WIN_BITS-1:0]          aq_addr_hi,
  input  logic [7:0]                   aq_addr_lo,
  input  logic [7:0]                   aq_data_in,
  output logic [7:0]                   aq_data_out,
  output logic                         aq_data_oe,
  input  logic                         aq_mreq_n,
  input  logic                         aq_iorq_n,
  input  logic                         aq_wr_n,
  input  logic                         aq_rd_n,
  input  logic                         aq_cart_n,
  output logic [(2**WIN_BITS)-1:0]     ram_ce_n,
  output logic [PAGE_BITS-1:0]         ram_page
);

  localparam int unsigned NWIN = 2**WIN_BITS;
  localparam int unsigned TOP  = NWIN - 1;
  localparam logic [NWIN-1:0] EN_RESET = MAP_MASK & ~(NWIN'(1) << TOP);

  logic [1:0] iorq_sync, wr_sync, rd_sync, cart_sync;
  logic       iorq_s, wr_s, rd_s, cart_s;
  logic       iowr, iord, iowr_prev, wr_pulse;

  logic [WIN_BITS-1:0]  sel;
  logic [NWIN-1:0]      en;
  logic [PAGE_BITS-1:0] page [NWIN];

  logic [7:0] rd_val;
  logic       port_hit;

  // Synchronisers keep sampling through reset so a strobe held across reset
  // is already seen as active at release; with iowr_prev reset to 1 no pulse fires.
  always_ff @(posedge aq_clk) begin
    iorq_sync <= {iorq_sync[0], aq_iorq_n};
    wr_sync   <= {wr_sync[0],   aq_wr_n};
    rd_sync   <= {rd_sync[0],   aq_rd_n};
    cart_sync <= {cart_sync[0], aq_cart_n};
  end

  assign iorq_s   = iorq_sync[1];
  assign wr_s     = wr_sync[1];
  assign rd_s     = rd_sync[1];
  assign cart_s   = cart_sync[1];
  assign iowr     = !iorq_s && !wr_s;
  assign iord     = !iorq_s && !rd_s;
  assign wr_pulse = iowr && !iowr_prev;

  always_ff @(posedge aq_clk) begin
    if (aq_reset) iowr_prev <= 1'b1;
    else          iowr_prev <= iowr;
  end

  always_ff @(posedge aq_clk) begin
    if (aq_reset) begin
      sel <= '0;
      en  <= EN_RESET;
      for (int unsigned i = 0; i < NWIN; i++) page[i] <= '0;
    end else begin
      if (wr_pulse && aq_addr_lo == SEL_PORT) begin
        sel <= aq_data_in[WIN_BITS-1:0];
        if (aq_data_in[7]) en[aq_data_in[WIN_BITS-1:0]] <= aq_data_in[6];
      end
      if (wr_pulse && aq_addr_lo == PAGE_PORT) page[sel] <= aq_data_in[PAGE_BITS-1:0];
      // Last assignment wins: an inserted cartridge overrides any enable write.
      if (!cart_s) en[TOP] <= 1'b0;
    end
  end

  always_comb begin
    rd_val   = '0;
    port_hit = 1'b0;
    if (aq_addr_lo == SEL_PORT) begin
      port_hit              = 1'b1;
      rd_val[7]             = en[sel];
      rd_val[WIN_BITS-1:0]  = sel;
    end else if (aq_addr_lo == PAGE_PORT) begin
      port_hit              = 1'b1;
      rd_val[PAGE_BITS-1:0] = page[sel];
    end
  end

  always_ff @(posedge aq_clk) begin
    if (aq_reset) begin
      aq_data_oe  <= 1'b0;
      aq_data_out <= '0;
    end else begin
      aq_data_oe  <= iord && port_hit;
      aq_data_out <= (iord && port_hit) ? rd_val : '0;
    end
  end

  always_comb begin
    ram_ce_n = '1;
    for (int unsigned w = 0; w < NWIN; w++) begin
      if (!aq_mreq_n && aq_addr_hi == WIN_BITS'(w) && MAP_MASK[w] && en[w])
        ram_ce_n[w] = 1'b0;
    end
  end

  assign ram_page = MAP_MASK[aq_addr_hi] ? page[aq_addr_hi] : '0;

endmodule

// File: tb/tb_paged_ram_mapper.sv
// Self-checking bench for paged_ram_mapper: directed scenarios plus randomized IO
// traffic checked against an array-based model of the mapper's registers.
module tb_paged_ram_mapper;

  localparam logic [3:0] MASK = 4'b1110;

  logic       aq_clk = 1'b0;
  logic       aq_reset;
  logic [1:0] aq_addr_hi;
  logic [7:0] aq_addr_lo, aq_data_in, aq_data_out;
  logic       aq_data_oe;
  logic       aq_mreq_n, aq_iorq_n, aq_wr_n, aq_rd_n, aq_cart_n;
  logic [3:0] ram_ce_n;
  logic [5:0] ram_page;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [5:0] m_page [4];
  logic [3:0] m_en;
  logic [1:0] m_sel;
  logic       m_cart;

  paged_ram_mapper #(
    .WIN_BITS(2), .PAGE_BITS(6), .SEL_PORT(8'hE6), .PAGE_PORT(8'hE7), .MAP_MASK(4'b1110)
  ) dut (
    .aq_clk(aq_clk), .aq_reset(aq_reset), .aq_addr_hi(aq_addr_hi), .aq_addr_lo(aq_addr_lo),
    .aq_data_in(aq_data_in), .aq_data_out(aq_data_out), .aq_data_oe(aq_data_oe),
    .aq_mreq_n(aq_mreq_n), .aq_iorq_n(aq_iorq_n), .aq_wr_n(aq_wr_n), .aq_rd_n(aq_rd_n),
    .aq_cart_n(aq_cart_n), .ram_ce_n(ram_ce_n), .ram_page(ram_page)
  );

  always #5 aq_clk = ~aq_clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_page[i] = '0;
    m_sel = '0;
    m_en  = 4'b0110;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    @(negedge aq_clk);
    aq_addr_lo = port; aq_data_in = d; aq_iorq_n = 1'b0; aq_wr_n = 1'b0;
    repeat (5) @(negedge aq_clk);
    aq_iorq_n = 1'b1; aq_wr_n = 1'b1;
    repeat (4) @(negedge aq_clk);
    if (port == 8'hE6) begin
      m_sel = d[1:0];
      if (d[7] && !(d[1:0] == 2'd3 && d[6] && !m_cart)) m_en[d[1:0]] = d[6];
    end else if (port == 8'hE7) begin
      m_page[m_sel] = d[5:0];
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] port);
    if (port == 8'hE6) return {m_en[m_sel], 5'b0, m_sel};
    if (port == 8'hE7) return {2'b00, m_page[m_sel]};
    return 8'h00;
  endfunction

  task automatic io_read(input logic [7:0] port, input string tag);
    int n;
    logic hit;
    logic [7:0] exp_d;
    hit   = (port == 8'hE6) || (port == 8'hE7);
    exp_d = model_read(port);
    @(negedge aq_clk);
    aq_addr_lo = port; aq_iorq_n = 1'b0; aq_rd_n = 1'b0;
    n = 0;
    while (!aq_data_oe && n < 8) begin
      @(negedge aq_clk);
      n++;
    end
    total++;
    if (hit) begin
      if (n !== 3) begin
        bad++;
        $display("FAIL %s oe_rise: got latency %0d need 3", tag, n);
      end
      total++;
      if (aq_data_out !== exp_d) begin
        bad++;
        $display("FAIL %s data: got %h need %h", tag, aq_data_out, exp_d);
      end
    end else if (aq_data_oe !== 1'b0) begin
      bad++;
      $display("FAIL %s oe_unused_port: got %b need 0", tag, aq_data_oe);
    end
    aq_iorq_n = 1'b1; aq_rd_n = 1'b1;
    repeat (3) @(negedge aq_clk);
    total++;
    if (aq_data_oe !== 1'b0) begin
      bad++;
      $display("FAIL %s oe_fall: got %b need 0", tag, aq_data_oe);
    end
    repeat (2) @(negedge aq_clk);
  endtask

  task automatic check_map(input string tag);
    logic [3:0] exp_ce;
    logic [5:0] exp_pg;
    for (int w = 0; w < 4; w++) begin
      @(negedge aq_clk);
      aq_addr_hi = 2'(w); aq_mreq_n = 1'b0;
      #1;
      exp_ce = 4'b1111;
      if (MASK[w] && m_en[w]) exp_ce[w] = 1'b0;
      exp_pg = MASK[w] ? m_page[w] : 6'd0;
      total++;
      if (ram_ce_n !== exp_ce) begin
        bad++;
        $display("FAIL %s ce win%0d: got %b need %b", tag, w, ram_ce_n, exp_ce);
      end
      total++;
      if (ram_page !== exp_pg) begin
        bad++;
        $display("FAIL %s page win%0d: got %h need %h", tag, w, ram_page, exp_pg);
      end
    end
    aq_mreq_n = 1'b1;
  endtask

  task automatic set_cart(input logic v);
    @(negedge aq_clk);
    aq_cart_n = v;
    repeat (4) @(negedge aq_clk);
    m_cart = v;
    if (!v) m_en[3] = 1'b0;
  endtask

  task automatic test_reset();
    aq_reset = 1'b1;
    repeat (5) @(negedge aq_clk);
    aq_reset = 1'b0;
    model_reset();
    total++;
    if (aq_data_oe !== 1'b0 || aq_data_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got oe=%b data=%h need 0/00", aq_data_oe, aq_data_out);
    end
    check_map("reset");
  endtask

  task automatic test_page_write();
    io_write(8'hE6, 8'h02);
    io_write(8'hE7, 8'h2A);
    check_map("page_write");
  endtask

  task automatic test_cart();
    io_write(8'hE6, 8'hC3);
    io_write(8'hE7, 8'h3F);
    check_map("cart_enabled");
    @(negedge aq_clk);
    aq_cart_n = 1'b0; aq_addr_hi = 2'd3; aq_mreq_n = 1'b0;
    repeat (3) @(posedge aq_clk);
    @(negedge aq_clk);
    total++;
    if (ram_ce_n[3] !== 1'b1) begin
      bad++;
      $display("FAIL cart_force: got ce3=%b need 1", ram_ce_n[3]);
    end
    aq_mreq_n = 1'b1;
    m_cart = 1'b0; m_en[3] = 1'b0;
    io_write(8'hE6, 8'hC3);
    check_map("cart_write_ignored");
    set_cart(1'b1);
    check_map("cart_removed");
    io_read(8'hE6, "cart_sel_read");
  endtask

  task automatic test_readback();
    io_write(8'hE6, 8'h01);
    io_write(8'hE7, 8'h15);
    io_read(8'hE7, "read_page");
    io_read(8'hE6, "read_sel");
  endtask

  task automatic test_boundary();
    io_write(8'hE7, 8'hFF);
    io_read(8'hE7, "page_trunc");
    io_write(8'hE5, 8'hC2);
    check_map("other_port_write");
    io_read(8'hE5, "other_port_read");
    io_read(8'hE6, "other_port_sel");
  endtask

  task automatic test_back_to_back();
    io_write(8'hE6, 8'h03);
    io_write(8'hE7, 8'h07);
    io_write(8'hE6, 8'h02);
    io_write(8'hE7, 8'h19);
    check_map("back_to_back");
  endtask

  task automatic test_reset_mid_write();
    io_write(8'hE6, 8'h00);
    @(negedge aq_clk);
    aq_addr_lo = 8'hE7; aq_data_in = 8'h11; aq_iorq_n = 1'b0; aq_wr_n = 1'b0;
    repeat (5) @(negedge aq_clk);
    aq_reset = 1'b1; aq_data_in = 8'h22;
    repeat (3) @(negedge aq_clk);
    aq_reset = 1'b0;
    model_reset();
    repeat (6) @(negedge aq_clk);
    check_map("reset_mid_map");
    aq_iorq_n = 1'b1; aq_wr_n = 1'b1;
    repeat (4) @(negedge aq_clk);
    io_read(8'hE7, "reset_mid_nowrite");
    io_write(8'hE7, 8'h2C);
    io_read(8'hE7, "reset_mid_fresh");
  endtask

  task automatic test_random();
    int op;
    logic [7:0] d, p;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      d  = 8'($urandom_range(0, 255));
      if (op <= 3) io_write(8'hE6, d);
      else if (op <= 6) io_write(8'hE7, d);
      else if (op == 7) begin
        p = 8'($urandom_range(0, 255));
        if (p == 8'hE6 || p == 8'hE7) p = 8'h10;
        io_write(p, d);
      end else if (op == 8) io_read(($urandom_range(0, 1) == 0) ? 8'hE6 : 8'hE7, "rand_read");
      else set_cart(~aq_cart_n);
      check_map("random");
    end
  endtask

  initial begin
    aq_reset = 1'b1; aq_addr_hi = '0; aq_addr_lo = '0; aq_data_in = '0;
    aq_mreq_n = 1'b1; aq_iorq_n = 1'b1; aq_wr_n = 1'b1; aq_rd_n = 1'b1; aq_cart_n = 1'b1;
    m_cart = 1'b1;
    model_reset();
    test_reset();
    test_page_write();
    test_cart();
    test_readback();
    test_boundary();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout need finish");
    $fatal(1, "timeout");
  end

endmodule
